// File: rtl/serial_word_comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states and the
// running equal/less/greater flag triple passed through the 1-bit cell.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic e;
        logic l;
        logic g;
    } cmp_flags_t;

    // Before any bit is seen the words are considered equal.
    localparam cmp_flags_t CMP_FLAGS_INIT = '{e: 1'b1, l: 1'b0, g: 1'b0};

endpackage

// File: rtl/serial_word_comparator_bit_cell.sv
// Cascadable 1-bit comparator cell: folds one bit pair (MSB first) into the
// running equal/less/greater flags.
module cmp_bit_cell
    import cmp_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  cmp_flags_t flags_in,
    output cmp_flags_t flags_out
);

    // Only the first differing bit decides; once e drops, l/g are frozen.
    assign flags_out.e = flags_in.e & (a_bit ~^ b_bit);
    assign flags_out.l = flags_in.l | (flags_in.e & ~a_bit &  b_bit);
    assign flags_out.g = flags_in.g | (flags_in.e &  a_bit & ~b_bit);

endmodule

// File: rtl/serial_word_comparator.sv
// Bit-serial unsigned magnitude comparator: one reused bit cell walks both
// operands MSB first over WIDTH cycles, then strobes done with eq/lt/gt.
module serial_word_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmp_flags_t       flags_q, flags_d;
    cmp_flags_t       res_q, res_d;
    cmp_flags_t       cell_out;

    cmp_bit_cell u_cell (
        .a_bit    (a_sh_q[WIDTH-1]),
        .b_bit    (b_sh_q[WIDTH-1]),
        .flags_in (flags_q),
        .flags_out(cell_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, shift and fold one bit per SHIFT cycle.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
        res_d   = res_q;
        if (state_q == IDLE && start) begin
            a_sh_d  = a;
            b_sh_d  = b;
            cnt_d   = CNT_W'(WIDTH - 1);
            flags_d = CMP_FLAGS_INIT;
        end else if (state_q == SHIFT) begin
            a_sh_d  = a_sh_q << 1;
            b_sh_d  = b_sh_q << 1;
            flags_d = cell_out;
            if (cnt_q == '0) begin
                res_d = cell_out;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        eq   = res_q.e;
        lt   = res_q.l;
        gt   = res_q.g;
    end

endmodule
